// File: rtl/log_pkg.sv
// ---------------------------------------------------------------------------
// log_pkg
// Shared definitions for the pipelined fixed-point logarithm unit.
//   - logMode_e     : per-sample base select carried down the pipe
//   - K_*_Q16       : multipliers that turn a Q16 log2 into the requested base
//   - lutValue()    : elaboration-time generator for the log2 mantissa table
// No ports; imported by log_pipe.
// ---------------------------------------------------------------------------
package log_pkg;

  // Base select as it arrives on in_mode; code 3 is left unnamed and
  // falls into the log2 path.
  typedef enum logic [1:0] {
    LOG_MODE_LOG2  = 2'd0,
    LOG_MODE_LN    = 2'd1,
    LOG_MODE_LOG10 = 2'd2
  } logMode_e;

  // Table entries and base constants are Q16 values up to and including 1.0.
  localparam int LUT_W = 17;

  // 1.0, 1/log2(e) and 1/log2(10) in Q16.
  localparam logic [LUT_W-1:0] K_LOG2_Q16  = 17'd65536;
  localparam logic [LUT_W-1:0] K_LN_Q16    = 17'd45426;
  localparam logic [LUT_W-1:0] K_LOG10_Q16 = 17'd19728;

  // round(2^16 * log2(1 + k/2^lutBits)) computed with integers only, so it
  // folds to a constant in both simulation and synthesis. The operand is
  // held in Q30 and squared repeatedly: each squaring that lands at or
  // above 2.0 contributes a 1 to the next fractional bit of the log.
  // 24 fractional bits are produced and then rounded down to 16.
  function automatic logic [LUT_W-1:0] lutValue(input int k, input int lutBits);
    logic [63:0] x;
    logic [23:0] frac;
    logic [63:0] intPart;
    logic [63:0] res;
    x       = 64'((1 << lutBits) + k) << (30 - lutBits);
    intPart = 64'd0;
    frac    = 24'd0;
    if (x >= (64'd2 << 30)) begin
      intPart = 64'd1;
      x       = x >> 1;
    end
    for (int b = 23; b >= 0; b--) begin
      x = (x * x) >> 30;
      if (x >= (64'd2 << 30)) begin
        frac[b] = 1'b1;
        x       = x >> 1;
      end
    end
    res = (intPart << 16) + ((64'(frac) + 64'd128) >> 8);
    return LUT_W'(res);
  endfunction

endpackage

// File: rtl/log_lzc.sv
// ---------------------------------------------------------------------------
// log_lzc
// Purely combinational leading-one detector. The parent registers the
// result.
//   i_data : operand to scan
//   o_idx  : bit position of the most significant 1 (0 when i_data is 0)
//   o_zero : high when i_data has no bit set
// ---------------------------------------------------------------------------
module log_lzc #(
  parameter int W     = 24,
  parameter int IDX_W = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]     i_data,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_zero
);

  // Scan upward from the LSB so the highest set bit is the last one
  // written, which gives priority to the MSB without a chain of elses.
  always_comb begin
    o_idx = '0;
    for (int i = 0; i < W; i++) begin
      if (i_data[i]) begin
        o_idx = IDX_W'(i);
      end
    end
  end

  // A separate zero flag, because o_idx is 0 both for "bit 0 set" and
  // for "no bit set".
  assign o_zero = ~|i_data;

endmodule

// File: rtl/log_pipe.sv
// ---------------------------------------------------------------------------
// log_pipe
// Five-stage pipelined logarithm of an unsigned fixed-point sample, with a
// per-sample base (log2 / ln / log10) and a pass-through channel tag.
// The whole pipe advances together and freezes while the output is held.
//   clk, reset            : clock, synchronous active-high reset
//   in_valid/in_ready     : input handshake (in_ready = not stalled)
//   in_data               : unsigned Q(IN_W-IN_FRAC).IN_FRAC operand
//   in_mode               : 0 log2, 1 ln, 2 log10, 3 treated as log2
//   in_ch                 : channel tag
//   out_valid/out_ready   : output handshake
//   out_data              : signed Q.OUT_FRAC result, saturated
//   out_ch                : tag belonging to out_data
//   out_zero              : operand was 0, out_data holds the minimum
// ---------------------------------------------------------------------------
module log_pipe
  import log_pkg::*;
#(
  parameter int IN_W        = 24,
  parameter int IN_FRAC     = 8,
  parameter int OUT_W       = 16,
  parameter int OUT_FRAC    = 8,
  parameter int LUT_BITS    = 6,
  parameter int INTERP_BITS = 8,
  parameter int CH_W        = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [IN_W-1:0]         in_data,
  input  logic [1:0]              in_mode,
  input  logic [CH_W-1:0]         in_ch,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic [CH_W-1:0]         out_ch,
  output logic                    out_zero
);

  localparam int IDX_W  = $clog2(IN_W);
  // Two spare bits keep p - IN_FRAC representable for any IN_FRAC <= IN_W.
  localparam int INT_W  = IDX_W + 2;
  localparam int MANT_W = IN_W - 1;
  localparam int TOP_W  = LUT_BITS + INTERP_BITS;
  localparam int LUT_N  = (1 << LUT_BITS) + 1;
  localparam int LOG_W  = INT_W + LUT_W;
  localparam int PW     = LOG_W + LUT_W + 1;
  // log2 is Q16 and the constant is Q16, so the product is Q32.
  localparam int SHIFT  = 32 - OUT_FRAC;
  localparam logic signed [PW-1:0]    SAT_MAX = PW'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [PW-1:0]    SAT_MIN = ~SAT_MAX;
  localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  logic w_stall;
  logic w_accept;

  logic                   r_v1, r_v2, r_v3, r_v4;
  logic [IN_W-1:0]        r1_data, r2_data;
  logic [1:0]             r1_mode, r2_mode, r3_mode, r4_mode;
  logic [CH_W-1:0]        r1_ch, r2_ch, r3_ch, r4_ch;
  logic [IDX_W-1:0]       r2_p;
  logic signed [INT_W-1:0] r2_int, r3_int;
  logic                   r2_zero, r3_zero, r4_zero;
  logic [LUT_BITS-1:0]    r3_idx;
  logic [INTERP_BITS-1:0] r3_frac;
  logic signed [LOG_W-1:0] r4_log;

  logic [IDX_W-1:0]          w_msb;
  logic                      w_zero;
  logic [IDX_W-1:0]          w_shift;
  logic [MANT_W-1:0]         w_mant;
  logic [MANT_W+TOP_W-1:0]   w_ext;
  logic [TOP_W-1:0]          w_top;
  logic [LUT_W-1:0]          w_lut [0:LUT_N-1];
  logic [LUT_BITS:0]         w_idxHi;
  logic [LUT_W-1:0]          w_lutLo, w_lutHi, w_diff, w_interp;
  logic [LUT_W+INTERP_BITS-1:0] w_mul;
  logic signed [LOG_W-1:0]   w_log;
  logic [LUT_W-1:0]          w_k;
  logic signed [PW-1:0]      w_prod, w_round, w_shr;
  logic signed [OUT_W-1:0]   w_sat;

  // One global stall keeps every stage aligned: bubbles stay where they are
  // instead of collapsing, so order and sample count are trivially kept.
  assign w_stall  = out_valid & ~out_ready;
  assign in_ready = ~w_stall;
  assign w_accept = in_valid & in_ready;

  log_lzc #(.W(IN_W), .IDX_W(IDX_W)) u_lzc (
    .i_data (r1_data),
    .o_idx  (w_msb),
    .o_zero (w_zero)
  );

  // Normalise: shift the leading one up to bit IN_W-1 and drop it. The
  // remaining mantissa is padded with zeros below so that short operands
  // still yield a full index/fraction field.
  assign w_shift = IDX_W'(MANT_W) - r2_p;
  assign w_mant  = MANT_W'(r2_data << w_shift);
  assign w_ext   = {w_mant, {TOP_W{1'b0}}};
  assign w_top   = TOP_W'(w_ext >> MANT_W);

  for (genvar k = 0; k < LUT_N; k++) begin : g_lut
    assign w_lut[k] = lutValue(k, LUT_BITS);
  end

  // Linear interpolation between neighbouring table points. The table is
  // monotonic, so the difference is never negative.
  assign w_idxHi  = (LUT_BITS+1)'(r3_idx) + (LUT_BITS+1)'(1);
  assign w_lutLo  = w_lut[r3_idx];
  assign w_lutHi  = w_lut[w_idxHi];
  assign w_diff   = w_lutHi - w_lutLo;
  assign w_mul    = (LUT_W+INTERP_BITS)'(w_diff) * (LUT_W+INTERP_BITS)'(r3_frac);
  assign w_interp = LUT_W'(w_mul >> INTERP_BITS);
  assign w_log    = (LOG_W'(r3_int) <<< 16) + LOG_W'(w_lutLo) + LOG_W'(w_interp);

  // Pick the base multiplier; the reserved code shares the log2 path.
  always_comb begin
    w_k = K_LOG2_Q16;
    case (r4_mode)
      LOG_MODE_LN:    w_k = K_LN_Q16;
      LOG_MODE_LOG10: w_k = K_LOG10_Q16;
      default:        w_k = K_LOG2_Q16;
    endcase
  end

  // Scale to the requested base, round half up, move to OUT_FRAC and clamp
  // into the signed output range.
  assign w_prod  = PW'(r4_log) * PW'($signed({1'b0, w_k}));
  assign w_round = w_prod + (PW'(1) <<< (SHIFT - 1));
  assign w_shr   = w_round >>> SHIFT;

  always_comb begin
    w_sat = OUT_W'(w_shr);
    if (w_shr > SAT_MAX) begin
      w_sat = OUT_MAX;
    end else if (w_shr < SAT_MIN) begin
      w_sat = OUT_MIN;
    end
  end

  // Pipeline registers. Every stage moves only when the output is not
  // being held; data fields load only behind a valid so idle stages keep
  // their last contents and the outputs stay put between results.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_v1      <= 1'b0;
      r_v2      <= 1'b0;
      r_v3      <= 1'b0;
      r_v4      <= 1'b0;
      out_valid <= 1'b0;
      r1_data   <= '0;
      r1_mode   <= '0;
      r1_ch     <= '0;
      r2_data   <= '0;
      r2_p      <= '0;
      r2_int    <= '0;
      r2_zero   <= 1'b0;
      r2_mode   <= '0;
      r2_ch     <= '0;
      r3_int    <= '0;
      r3_idx    <= '0;
      r3_frac   <= '0;
      r3_zero   <= 1'b0;
      r3_mode   <= '0;
      r3_ch     <= '0;
      r4_log    <= '0;
      r4_zero   <= 1'b0;
      r4_mode   <= '0;
      r4_ch     <= '0;
      out_data  <= '0;
      out_ch    <= '0;
      out_zero  <= 1'b0;
    end else if (!w_stall) begin
      r_v1      <= w_accept;
      r_v2      <= r_v1;
      r_v3      <= r_v2;
      r_v4      <= r_v3;
      out_valid <= r_v4;
      if (w_accept) begin
        r1_data <= in_data;
        r1_mode <= in_mode;
        r1_ch   <= in_ch;
      end
      if (r_v1) begin
        r2_data <= r1_data;
        r2_p    <= w_msb;
        r2_int  <= INT_W'(w_msb) - INT_W'(IN_FRAC);
        r2_zero <= w_zero;
        r2_mode <= r1_mode;
        r2_ch   <= r1_ch;
      end
      if (r_v2) begin
        r3_int  <= r2_int;
        r3_idx  <= w_top[TOP_W-1 -: LUT_BITS];
        r3_frac <= w_top[INTERP_BITS-1:0];
        r3_zero <= r2_zero;
        r3_mode <= r2_mode;
        r3_ch   <= r2_ch;
      end
      if (r_v3) begin
        r4_log  <= w_log;
        r4_zero <= r3_zero;
        r4_mode <= r3_mode;
        r4_ch   <= r3_ch;
      end
      if (r_v4) begin
        out_data <= r4_zero ? OUT_MIN : w_sat;
        out_ch   <= r4_ch;
        out_zero <= r4_zero;
      end
    end
  end

endmodule

// File: doc/log_pipe.md
Name: log_pipe

Overview:
- Pipelined, parametrised fixed-point logarithm unit for the discrete-audio math library.
- Accepts unsigned fixed-point samples with a channel tag and a per-sample base select (ln, log2, log10).
- Returns a signed fixed-point result after a fixed latency, with valid/ready backpressure.
- Used by diode/transistor models that time-multiplex several channels through one log core.

Parameters:
- IN_W, 24, input width (unsigned)
- IN_FRAC, 8, input fractional bits
- OUT_W, 16, output width (signed)
- OUT_FRAC, 8, output fractional bits
- LUT_BITS, 6, mantissa bits indexing the log2 table (2^LUT_BITS+1 entries)
- INTERP_BITS, 8, mantissa bits below the LUT index used for linear interpolation
- CH_W, 3, channel tag width

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  input sample present
- in_ready  out  1  unit accepts a sample this cycle
- in_data  in  IN_W  unsigned Q(IN_W-IN_FRAC).IN_FRAC operand
- in_mode  in  2  0=log2, 1=ln, 2=log10, 3=reserved (treated as log2)
- in_ch  in  CH_W  channel tag, passed through unchanged
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts the result
- out_data  out  OUT_W  signed Q.OUT_FRAC result
- out_ch  out  CH_W  tag of the result
- out_zero  out  1  operand was 0; out_data is the saturated minimum

Behaviour:
- Clock is clk. Reset is synchronous and active-high.
- Reset clears all stage valids, out_valid, out_data, out_ch and out_zero to 0; in_ready is 1 in the cycle after reset deasserts.
- Reset mid-operation discards in-flight samples; nothing is emitted afterwards.
- Pipeline has 5 registered stages; latency is exactly 5 cycles from an accepted input to out_valid when not stalled.
  - S1: capture operand, mode and tag.
  - S2: priority-encode msb index p; int = p - IN_FRAC (signed).
  - S3: normalise the mantissa (left-shift so the msb is dropped); extract the LUT index and the interpolation fraction.
  - S4: log2 = int·2^16 + LUT[i] + ((LUT[i+1]-LUT[i])·f >> INTERP_BITS); internal signed Q.16, width ≥ 22.
  - S5: multiply by the base constant, round, convert to OUT_FRAC, saturate, then register the outputs.
- LUT contents: round(2^16·log2(1+k/2^LUT_BITS)), k = 0..2^LUT_BITS.
- Base constants (Q16): log2 = 65536, ln = 45426, log10 = 19728.
- Rounding: add 2^(shift-1) before the arithmetic right shift. Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- If the mantissa has fewer bits than LUT_BITS+INTERP_BITS, zero-fill the missing LSBs.
- Zero operand: out_data = -2^(OUT_W-1), out_zero = 1; the tag is still passed through.
- Handshake:
  - A transfer happens on valid && ready.
  - stall = out_valid && !out_ready. When stalled, every stage holds its value.
  - in_ready = !stall (combinational). Full throughput is 1 sample/cycle.
  - out_data, out_ch and out_zero stay stable while out_valid && !out_ready.
  - Bubbles propagate as invalid stages; no sample is dropped or duplicated.
- Order is preserved. A simultaneous input accept and output drain in the same cycle is legal.

Decomposition:
- Package log_pkg holds:
  - the mode enum (LOG_MODE_LOG2, LOG_MODE_LN, LOG_MODE_LOG10);
  - the base constants K_LOG2_Q16, K_LN_Q16, K_LOG10_Q16;
  - a function generating the LUT value for index k (elaboration-time).
- One sub-module, log_lzc: a parametrised leading-one detector (IN_W → msb index plus a zero flag), purely combinational, registered by the parent.

Test Plan:
- Default parameters, log2 mode:
  - in_data=256 (1.0) → out_data=0, out_zero=0, out_valid exactly 5 cycles after acceptance.
  - in_data=512 (2.0): log2 → 256; ln → 177; log10 → 77 (three back-to-back samples, tags 1,2,3, returned in order).
  - in_data=1 (2^-8), log2 → -2048; in_data=0xFFFFFF, log2 → 4096 ±1 LSB.
  - in_data=0, tag 5 → out_data=-32768, out_zero=1, out_ch=5.
- Stream of 20 random operands, with out_ready low for 4 cycles mid-stream → in_ready low while stalled, outputs stable, all 20 results match the model within ±1 LSB, order kept.
- Assert reset for 1 cycle with 3 samples in flight → out_valid stays 0 and outputs are 0. A new sample in_data=256 afterwards → 0 after 5 cycles.
